// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory arbiter for IF/DM/loader with read-owner tracking; ARB_STARVE_GUARD_EN adds IF starvation promotion.
module mem_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  input  logic          halted,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_e;
  typedef enum logic [1:0] {O_NONE, O_IF, O_DM} owner_e;
  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   arb, promote;
`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_q, wait_d;
  assign promote = wait_q == CW'(MAX_WAIT);
  assign wait_d  = (arb && if_req && !if_gnt) ? wait_q + CW'(1) : '0;
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
`else
  assign promote = 1'b0;
`endif
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      owner_q <= O_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  always_comb begin
    state_d = state_q == RUN   ? (halted ? (owner_q != O_NONE ? DRAIN : LOAD) : RUN) :
              state_q == DRAIN ? LOAD : (halted ? LOAD : RUN);
    owner_d = if_gnt ? O_IF : (dm_gnt && !dm_we) ? O_DM : O_NONE;
  end
  // Grants are gated by rst_n so nothing reaches the memory while reset is held
  always_comb begin
    arb       = rst_n && state_q == RUN && !halted;
    dm_gnt    = arb && dm_req && !(promote && if_req);
    if_gnt    = arb && if_req && (!dm_req || promote);
    ld_gnt    = rst_n && state_q == LOAD && halted && ld_req;
    mem_en    = if_gnt || dm_gnt || ld_gnt;
    mem_we    = ld_gnt || (dm_gnt && dm_we);
    mem_addr  = if_gnt ? if_addr : dm_gnt ? dm_addr : ld_gnt ? ld_addr : '0;
    mem_wdata = dm_gnt ? dm_wdata : ld_gnt ? ld_wdata : '0;
    if_rvalid = owner_q == O_IF;
    dm_rvalid = owner_q == O_DM;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
    busy      = owner_q != O_NONE || state_q != RUN;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and sequencer for the MIPS32 core's shared 1024 x 32 instruction/data memory. Grants each cycle to one of three requesters: instruction fetch (IF, read-only), data access from the MEM stage (DM, read/write), and a program loader (LD, write-only, active only while the core is halted). Tracks the owner of each outstanding read so returned data is steered back to the right requester, and exposes per-requester stall information through the grant signals.

## Interface
Parameters:
- AW, 10, memory word-address width (1024 words)
- DW, 32, data width
- MAX_WAIT, 4, consecutive denied IF cycles before IF is promoted (only with ARB_STARVE_GUARD_EN)

Ports:
- clk1  in  1  single clock; all state updates on posedge clk1
- rst_n  in  1  asynchronous, active-low reset
- if_req / if_addr  in  1 / AW  fetch read request and word address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid / if_rdata  out  1 / DW  fetch data return
- dm_req, dm_we  in  1, 1  data request; dm_we=1 store, 0 load
- dm_addr / dm_wdata  in  AW / DW  data address, store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid / dm_rdata  out  1 / DW  load data return
- ld_req / ld_addr / ld_wdata  in  1 / AW / DW  loader write request
- ld_gnt  out  1  loader write accepted this cycle
- halted  in  1  core HALTED flag
- mem_en, mem_we  out  1, 1  memory port enable, write enable
- mem_addr / mem_wdata  out  AW / DW  memory port address, write data
- mem_rdata  in  DW  synchronous-read data, valid the cycle after mem_en && !mem_we
- busy  out  1  read outstanding or state != RUN

## Operation
- FSM states: RUN, DRAIN, LOAD. Reset state RUN.
- RUN: if halted=1, go to DRAIN if a read is outstanding, else directly to LOAD. Otherwise arbitrate IF vs DM.
- DRAIN: no grants; return of outstanding read completes; next cycle LOAD.
- LOAD: only LD is granted; IF/DM gnt held 0. If halted=0, go to RUN (ld_req ignored that cycle).
- RUN priority: DM over IF (strict). LD never granted in RUN or DRAIN.
- Grants are combinational from current state and requests; exactly one of if_gnt/dm_gnt/ld_gnt high per cycle, or none.
- mem_en = OR of grants; mem_addr/mem_we/mem_wdata muxed from the granted requester; outputs are 0 when no grant.
- Owner register (NONE/IF/DM) captures the granted reader on a granted read; cleared otherwise.
- Cycle after a granted read: rvalid pulsed for owner only; rdata = mem_rdata. Non-owner rdata driven 0.
- Stores and loader writes produce no rvalid.
- Requesters hold req/addr/data stable until gnt; deasserting without gnt is legal and leaves no side effect.

## Timing
- Grant: same cycle as req (zero latency) when winning.
- Read latency: grant in cycle N -> rvalid in N+1; back-to-back reads at one per cycle.
- Write: committed at the clock edge ending the grant cycle.
- RUN -> LOAD: 1 cycle (no read outstanding) or 2 cycles (via DRAIN).
- LOAD -> RUN: 1 cycle after halted falls.
- Simultaneous if_req and dm_req: dm_gnt=1, if_gnt=0 (unless starvation promotion active).
- Reset (any time, including mid-read): state RUN, owner NONE, wait counter 0, all rvalid 0 immediately; a pending read is dropped. All gnt/mem outputs 0 while rst_n=0.

## Configuration
- ARB_STARVE_GUARD_EN defined: counter of consecutive cycles with if_req=1 and if_gnt=0 in RUN; when count == MAX_WAIT, next RUN cycle with both requests grants IF, then counter clears. Counter clears on any if_gnt, if_req=0, or leaving RUN. Counter width clog2(MAX_WAIT+1).
- Not defined: strict DM-over-IF priority; no counter logic present.

## Test plan
- Reset mid-read: grant IF read at addr 0x005, assert rst_n=0 next cycle -> if_rvalid stays 0, all outputs 0, state RUN after release.
- Contention: if_req and dm_req (load, addr 0x010, mem[0x010]=0xDEADBEEF) together -> dm_gnt=1, if_gnt=0; next cycle dm_rvalid=1, dm_rdata=0xDEADBEEF, if_rvalid=0.
- Back-to-back: IF reads 0x000..0x003 on consecutive cycles, no DM -> four if_rvalid pulses, data in address order, one cycle behind each grant.
- Halt/load: IF read granted, halted rises next cycle -> DRAIN one cycle, then LOAD; ld writes 0x1234_5678 to 0x020 -> ld_gnt=1, mem_we=1; if_req during LOAD -> if_gnt=0; halted falls -> RUN, IF granted next cycle.
- Starvation (ARB_STARVE_GUARD_EN, MAX_WAIT=4): dm_req and if_req held continuously -> dm_gnt for 4 cycles, if_gnt on 5th, then DM again; without macro if_gnt never asserts.
